tia_horizontal_sequencer: RTL

//  Horizontal line sequencer for the TIA. It owns the reset (rsyn) of the biphase clock

---
 rtl/tia_horizontal_sequencer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/tia_horizontal_sequencer.sv
// ---------------------------------------------------------------------------
// tia_horizontal_sequencer
//
// Horizontal line sequencer for the TIA. It holds the biphase clock generator
// in reset through rsyn, counts rising edges of phi2 to produce the 57-count
// horizontal sync counter (hsc), and decodes hsync/hblank from it. A WSYNC
// strobe halts the CPU (rdy=0) until the end of the line. An RSYNC strobe
// restarts the line immediately.
//
// Optional feature macro: TIA_HSEQ_HMOVE_EN
//   defined   : an HMOVE strobe sets a per-line latch that extends hblank
//               to LATE_HBLANK_END on that line.
//   undefined : the hmove input is ignored, no latch exists, and hblank
//               always ends at HBLANK_END.
//
// All outputs come straight from flops. The only reset is the asynchronous,
// active-high r.
// ---------------------------------------------------------------------------
module tia_horizontal_sequencer #(
    parameter int LINE_COUNTS     = 57,
    parameter int HSYNC_START     = 4,
    parameter int HSYNC_END       = 8,
    parameter int HBLANK_END      = 17,
    parameter int LATE_HBLANK_END = 19
) (
    input  logic       clk,
    input  logic       r,
    input  logic       phi1,
    input  logic       phi2,
    input  logic       wsync,
    input  logic       rsync,
    input  logic       hmove,
    output logic       rsyn,
    output logic [5:0] hsc,
    output logic       hsync,
    output logic       hblank,
    output logic       rdy,
    output logic       line_start,
    output logic       phase_err
);

    localparam logic [5:0] HSC_LAST        = 6'(LINE_COUNTS - 1);
    localparam logic [5:0] HSYNC_SET_AT    = 6'(HSYNC_START);
    localparam logic [5:0] HSYNC_CLR_AT    = 6'(HSYNC_END);
    localparam logic [5:0] HBLANK_CLR_AT   = 6'(HBLANK_END);
    localparam logic [5:0] HBLANK_LATE_AT  = 6'(LATE_HBLANK_END);

    // State registers
    logic       rsyn_r;
    logic [5:0] hsc_r;
    logic       hsync_r;
    logic       hblank_r;
    logic       rdy_r;
    logic       line_start_r;
    logic       phase_err_r;
    logic       phi2_q_r;

    // Next-state values
    logic       rsyn_nxt_s;
    logic [5:0] hsc_nxt_s;
    logic       hsync_nxt_s;
    logic       hblank_nxt_s;
    logic       rdy_nxt_s;
    logic       line_start_nxt_s;
    logic       phase_err_nxt_s;
    logic       phi2_q_nxt_s;

    // Line control strobes
    logic       adv_s;
    logic       wrap_s;
    logic       restart_s;
    logic       late_blank_s;
    logic [5:0] hblank_end_s;
    logic [5:0] hsc_inc_s;

`ifdef TIA_HSEQ_HMOVE_EN
    logic       hmove_latch_r;
    logic       hmove_latch_nxt_s;

    // The late-blank selection comes from the latch of the current line.
    assign late_blank_s = hmove_latch_r;
`else
    // Without the HMOVE feature no line is ever extended and hmove is unused.
    logic       hmove_unused_s;

    assign late_blank_s   = 1'b0;
    assign hmove_unused_s = hmove;
`endif

    // A phi2 rising edge is one HSC count. While rsyn is high the history is
    // treated as high, so a phi2 phase already in progress is never counted.
    assign adv_s        = phi2 & ~phi2_q_r & ~rsyn_r;
    assign wrap_s       = adv_s & (hsc_r == HSC_LAST);
    assign restart_s    = wrap_s | rsync;
    assign hsc_inc_s    = hsc_r + 6'd1;
    assign hblank_end_s = late_blank_s ? HBLANK_LATE_AT : HBLANK_CLR_AT;

    // Next-state logic: line restart (wrap or RSYNC), count advance, WSYNC, error.
    always_comb begin
        rsyn_nxt_s       = 1'b0;
        line_start_nxt_s = 1'b0;
        hsc_nxt_s        = hsc_r;
        hsync_nxt_s      = hsync_r;
        hblank_nxt_s     = hblank_r;
        rdy_nxt_s        = rdy_r;
        phase_err_nxt_s  = phase_err_r | (phi1 & phi2);
        phi2_q_nxt_s     = rsyn_r ? 1'b1 : phi2;
`ifdef TIA_HSEQ_HMOVE_EN
        hmove_latch_nxt_s = hmove_latch_r;
`endif

        if (restart_s) begin
            // Wrap and RSYNC share one path, so a coincident pair gives a
            // single rsyn pulse.
            hsc_nxt_s        = 6'd0;
            rsyn_nxt_s       = 1'b1;
            line_start_nxt_s = 1'b1;
            hblank_nxt_s     = 1'b1;
            rdy_nxt_s        = 1'b1;
`ifdef TIA_HSEQ_HMOVE_EN
            hmove_latch_nxt_s = 1'b0;
`endif
            if (rsync) begin
                hsync_nxt_s = 1'b0;
            end else begin
                hsync_nxt_s = hsync_r;
            end
        end else if (adv_s) begin
            hsc_nxt_s = hsc_inc_s;
            if (hsc_inc_s == HSYNC_SET_AT) begin
                hsync_nxt_s = 1'b1;
            end else if (hsc_inc_s == HSYNC_CLR_AT) begin
                hsync_nxt_s = 1'b0;
            end else begin
                hsync_nxt_s = hsync_r;
            end
            if (hsc_inc_s == hblank_end_s) begin
                hblank_nxt_s = 1'b0;
            end else begin
                hblank_nxt_s = hblank_r;
            end
        end else begin
            hsc_nxt_s = hsc_r;
        end

        // WSYNC is applied after any restart, so it wins over the release.
        if (wsync) begin
            rdy_nxt_s = 1'b0;
        end else begin
            rdy_nxt_s = rdy_nxt_s;
        end

`ifdef TIA_HSEQ_HMOVE_EN
        // The latch belongs to the line being started, so a set beats the clear.
        if (hmove) begin
            hmove_latch_nxt_s = 1'b1;
        end else begin
            hmove_latch_nxt_s = hmove_latch_nxt_s;
        end
`endif
    end

    // Sequencer state register with asynchronous line reset.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            rsyn_r       <= 1'b1;
            hsc_r        <= 6'd0;
            hsync_r      <= 1'b0;
            hblank_r     <= 1'b1;
            rdy_r        <= 1'b1;
            line_start_r <= 1'b0;
            phase_err_r  <= 1'b0;
            phi2_q_r     <= 1'b1;
        end else begin
            rsyn_r       <= rsyn_nxt_s;
            hsc_r        <= hsc_nxt_s;
            hsync_r      <= hsync_nxt_s;
            hblank_r     <= hblank_nxt_s;
            rdy_r        <= rdy_nxt_s;
            line_start_r <= line_start_nxt_s;
            phase_err_r  <= phase_err_nxt_s;
            phi2_q_r     <= phi2_q_nxt_s;
        end
    end

`ifdef TIA_HSEQ_HMOVE_EN
    // HMOVE latch register, cleared by reset and at each line restart.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            hmove_latch_r <= 1'b0;
        end else begin
            hmove_latch_r <= hmove_latch_nxt_s;
        end
    end
`endif

    assign rsyn       = rsyn_r;
    assign hsc        = hsc_r;
    assign hsync      = hsync_r;
    assign hblank     = hblank_r;
    assign rdy        = rdy_r;
    assign line_start = line_start_r;
    assign phase_err  = phase_err_r;

endmodule
